// File: rtl/dram_sched_pkg.sv
// Shared definitions for the DRAM burst scheduler.
//   state_t              : scheduler FSM states
//   DEFAULT_REGION_SHIFT : default log2 of a client's region size in words
//   MAX_SAME_DIR         : cap on consecutive same-direction grants when the
//                          direction-preference build option is enabled
package dram_sched_pkg;

  typedef enum logic [1:0] {
    WAIT_INIT,
    ARB,
    OFFER,
    BUSY
  } state_t;

  localparam int DEFAULT_REGION_SHIFT = 14;
  localparam int MAX_SAME_DIR         = 4;

endpackage

// File: rtl/dram_burst_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req       : per-client request vector
//   mask      : preferred subset; used only if it leaves at least one requester
//   rr_last   : last granted client; the scan starts at rr_last+1 and wraps
//   gnt_valid : some eligible client is requesting
//   gnt_id    : first eligible requester in rotated order
module rr_arbiter #(
  parameter  int NUM_CLIENTS = 6,
  localparam int ID_W        = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [NUM_CLIENTS-1:0] mask,
  input  logic [ID_W-1:0]        rr_last,
  output logic                   gnt_valid,
  output logic [ID_W-1:0]        gnt_id
);

  logic [NUM_CLIENTS-1:0] eligible;
  logic [ID_W-1:0]        idx;

  // NOTE: every signal written here gets a value before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    eligible  = ((req & mask) != '0) ? (req & mask) : req;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      idx = ID_W'((int'(rr_last) + k) % NUM_CLIENTS);
      if (!gnt_valid && eligible[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
  end

endmodule

// File: rtl/dram_burst_scheduler.sv
// dram_burst_scheduler: round-robin sharing of the MIG UI port between burst
// clients. Each client owns region (id << REGION_SHIFT) and a word pointer
// that advances by the granted length when the engine reports burst_done.
//
// Ports:
//   clk_in, rst_in       : MIG UI clock, async active-high reset
//   init_calib_complete  : no grant is issued before this first goes high
//   client_req           : level requests, one bit per client
//   client_restart       : one-cycle pulse, clears that client's pointer
//   grant_valid/ready    : grant handshake towards the command engine
//   grant_id/is_write/addr/len : grant contents, stable while grant_valid
//   burst_done           : last word of the accepted burst issued
//   frame_done           : one-cycle pulse when a client's pointer wraps
//   busy                 : grant accepted, burst not yet done
//
// Build option: define SAME_DIR_PREF_EN to prefer requesters matching the
// previous grant's direction (up to MAX_SAME_DIR grants in a row).
module dram_burst_scheduler
  import dram_sched_pkg::*;
#(
  parameter int                     NUM_CLIENTS  = 6,
  parameter logic [NUM_CLIENTS-1:0] WR_MASK      = 6'b000111,
  parameter int                     BURST_LEN    = 16,
  parameter int                     FRAME_WORDS  = 15200,
  parameter int                     REGION_SHIFT = DEFAULT_REGION_SHIFT,
  parameter int                     ADDR_W       = 27
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           init_calib_complete,
  input  logic [NUM_CLIENTS-1:0]         client_req,
  input  logic [NUM_CLIENTS-1:0]         client_restart,
  output logic                           grant_valid,
  input  logic                           grant_ready,
  output logic [$clog2(NUM_CLIENTS)-1:0] grant_id,
  output logic                           grant_is_write,
  output logic [ADDR_W-1:0]              grant_addr,
  output logic [$clog2(BURST_LEN):0]     grant_len,
  input  logic                           burst_done,
  output logic [NUM_CLIENTS-1:0]         frame_done,
  output logic                           busy
);

  localparam int ID_W  = $clog2(NUM_CLIENTS);
  localparam int LEN_W = $clog2(BURST_LEN) + 1;
  localparam int PTR_W = $clog2(FRAME_WORDS + 1);

  state_t            state, state_next;
  logic [PTR_W-1:0]  ptr [NUM_CLIENTS];
  logic [ID_W-1:0]   rr_last;

  logic              arb_valid;
  logic [ID_W-1:0]   arb_id;
  logic [NUM_CLIENTS-1:0] arb_mask;
  logic [31:0]       remain;
  logic [LEN_W-1:0]  len_next;
  logic [31:0]       ptr_sum;

  logic              load_grant;
  logic              accept;
  logic              finish;

  // ---------------------------------------------------------------------------
  // Direction preference
  // ---------------------------------------------------------------------------
`ifdef SAME_DIR_PREF_EN
  logic [2:0] same_dir_cnt;
  logic       last_dir_write;
  logic       want_write;

  // Once the same-direction run reaches the cap, the preference flips so the
  // other direction gets served before the run can continue.
  always_comb begin
    want_write = (same_dir_cnt >= 3'(MAX_SAME_DIR)) ? ~last_dir_write : last_dir_write;
    arb_mask   = want_write ? WR_MASK : ~WR_MASK;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      same_dir_cnt   <= '0;
      last_dir_write <= 1'b1;
    end else if (accept) begin
      if (grant_is_write == last_dir_write) begin
        if (same_dir_cnt < 3'(MAX_SAME_DIR)) same_dir_cnt <= same_dir_cnt + 3'd1;
      end else begin
        same_dir_cnt   <= 3'd1;
        last_dir_write <= grant_is_write;
      end
    end
  end
`else
  assign arb_mask = '1;
`endif

  rr_arbiter #(.NUM_CLIENTS(NUM_CLIENTS)) u_rr (
    .req       (client_req),
    .mask      (arb_mask),
    .rr_last   (rr_last),
    .gnt_valid (arb_valid),
    .gnt_id    (arb_id)
  );

  // Burst length is clipped so a burst never crosses the end of the frame.
  always_comb begin
    remain   = 32'(FRAME_WORDS) - 32'(ptr[arb_id]);
    len_next = (remain >= 32'(BURST_LEN)) ? LEN_W'(BURST_LEN) : LEN_W'(remain);
    ptr_sum  = 32'(ptr[grant_id]) + 32'(grant_len);
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= WAIT_INIT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_grant = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      WAIT_INIT: if (init_calib_complete) state_next = ARB;
      ARB: begin
        if (arb_valid) begin
          load_grant = 1'b1;
          state_next = OFFER;
        end
      end
      OFFER: begin
        if (grant_ready) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (burst_done) begin
          finish     = 1'b1;
          state_next = ARB;
        end
      end
      default: state_next = WAIT_INIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Grant registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      grant_valid    <= 1'b0;
      grant_id       <= '0;
      grant_is_write <= 1'b0;
      grant_addr     <= '0;
      grant_len      <= '0;
      busy           <= 1'b0;
      rr_last        <= ID_W'(NUM_CLIENTS - 1);
    end else begin
      if (load_grant) begin
        grant_valid    <= 1'b1;
        grant_id       <= arb_id;
        grant_is_write <= WR_MASK[arb_id];
        grant_addr     <= (ADDR_W'(arb_id) << REGION_SHIFT) + ADDR_W'(ptr[arb_id]);
        grant_len      <= len_next;
      end
      if (accept) begin
        grant_valid <= 1'b0;
        busy        <= 1'b1;
        rr_last     <= grant_id;
      end
      if (finish) busy <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-client pointers. A restart overrides a coincident advance, so a frame
  // restarted on its last burst never reports frame_done.
  // ---------------------------------------------------------------------------
  // NOTE: the pointer array is only NUM_CLIENTS registers and must start at 0,
  // so it is reset like ordinary flops rather than treated as a RAM.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_CLIENTS; i++) ptr[i] <= '0;
      frame_done <= '0;
    end else begin
      frame_done <= '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (client_restart[i]) begin
          ptr[i] <= '0;
        end else if (finish && (grant_id == ID_W'(i))) begin
          if (ptr_sum >= 32'(FRAME_WORDS)) begin
            ptr[i]        <= '0;
            frame_done[i] <= 1'b1;
          end else begin
            ptr[i] <= PTR_W'(ptr_sum);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_burst_scheduler.sv
// Self-checking bench for dram_burst_scheduler. A transaction-level model
// (per-client pointers, round-robin pick from the requests seen) checks the
// grant contents, busy and frame_done every cycle; directed sequences add
// hand-computed literal expectations. A second instance uses FRAME_WORDS=40
// to exercise the short final burst.
module tb_dram_burst_scheduler;

  localparam int N  = 6;
  localparam int FW = 15200;
  localparam int BL = 16;
  localparam logic [N-1:0] WRM = 6'b000111;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          init_calib_complete = 1'b0;
  logic [N-1:0]  client_req = '0;
  logic [N-1:0]  client_restart = '0;
  logic          grant_valid;
  logic          grant_ready = 1'b0;
  logic [2:0]    grant_id;
  logic          grant_is_write;
  logic [26:0]   grant_addr;
  logic [4:0]    grant_len;
  logic          burst_done = 1'b0;
  logic [N-1:0]  frame_done;
  logic          busy;

  // second instance, short frame
  logic [N-1:0]  req40 = '0;
  logic [N-1:0]  restart40 = '0;
  logic          valid40;
  logic          ready40 = 1'b0;
  logic [2:0]    id40;
  logic          wr40;
  logic [26:0]   addr40;
  logic [4:0]    len40;
  logic          done40 = 1'b0;
  logic [N-1:0]  fd40;
  logic          busy40;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_in = ~clk_in;

  dram_burst_scheduler dut (
    .clk_in(clk_in), .rst_in(rst_in), .init_calib_complete(init_calib_complete),
    .client_req(client_req), .client_restart(client_restart),
    .grant_valid(grant_valid), .grant_ready(grant_ready), .grant_id(grant_id),
    .grant_is_write(grant_is_write), .grant_addr(grant_addr), .grant_len(grant_len),
    .burst_done(burst_done), .frame_done(frame_done), .busy(busy)
  );

  dram_burst_scheduler #(.FRAME_WORDS(40)) dut40 (
    .clk_in(clk_in), .rst_in(rst_in), .init_calib_complete(init_calib_complete),
    .client_req(req40), .client_restart(restart40),
    .grant_valid(valid40), .grant_ready(ready40), .grant_id(id40),
    .grant_is_write(wr40), .grant_addr(addr40), .grant_len(len40),
    .burst_done(done40), .frame_done(fd40), .busy(busy40)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int        m_ptr [N];
  int        m_rr_last;
  bit        m_busy;
  int        m_id, m_len;
  bit [N-1:0] m_fd;
  bit [N-1:0] req_seen;
  bit        prev_valid;
  int        cap_id, cap_addr, cap_len, cap_wr;
  bit        m_last_wr;
  int        m_same_cnt;

  function automatic int model_pick(input bit [N-1:0] req);
    bit [N-1:0] cand;
    int c;
    cand = req;
`ifdef SAME_DIR_PREF_EN
    begin
      bit want_wr;
      bit [N-1:0] pref;
      want_wr = (m_same_cnt >= 4) ? !m_last_wr : m_last_wr;
      pref = want_wr ? (req & WRM) : (req & ~WRM);
      if (pref != '0) cand = pref;
    end
`endif
    for (int k = 1; k <= N; k++) begin
      c = (m_rr_last + k) % N;
      if (cand[c]) return c;
    end
    return -1;
  endfunction

  always @(negedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < N; i++) m_ptr[i] = 0;
      m_rr_last  = N - 1;
      m_busy     = 1'b0;
      m_fd       = '0;
      m_id       = 0;
      m_len      = 0;
      prev_valid = 1'b0;
      req_seen   = '0;
      m_last_wr  = 1'b1;
      m_same_cnt = 0;
    end else begin
      check("busy", 32'(busy), 32'(m_busy));
      check("frame_done", 32'(frame_done), 32'(m_fd));
      if (grant_valid) begin
        if (!prev_valid) begin
          int e;
          e = model_pick(req_seen);
          check("grant_id", 32'(grant_id), e);
          if (e >= 0) begin
            m_id  = e;
            m_len = (FW - m_ptr[e] < BL) ? FW - m_ptr[e] : BL;
            check("grant_addr", 32'(grant_addr), (e << 14) + m_ptr[e]);
            check("grant_len", 32'(grant_len), m_len);
            check("grant_is_write", 32'(grant_is_write), 32'(WRM[e]));
          end
          cap_id = grant_id; cap_addr = grant_addr; cap_len = grant_len; cap_wr = grant_is_write;
        end else begin
          check("hold_id", 32'(grant_id), cap_id);
          check("hold_addr", 32'(grant_addr), cap_addr);
          check("hold_len", 32'(grant_len), cap_len);
          check("hold_wr", 32'(grant_is_write), cap_wr);
        end
      end
      prev_valid = grant_valid;

      // expectations for the next cycle
      m_fd = '0;
      if (grant_valid && grant_ready) begin
        m_busy    = 1'b1;
        m_rr_last = m_id;
        if (WRM[m_id] == m_last_wr) begin
          if (m_same_cnt < 4) m_same_cnt++;
        end else begin
          m_same_cnt = 1;
          m_last_wr  = WRM[m_id];
        end
      end else if (m_busy && burst_done) begin
        int nxt;
        m_busy = 1'b0;
        nxt = m_ptr[m_id] + m_len;
        if (!client_restart[m_id]) begin
          if (nxt >= FW) begin
            m_ptr[m_id] = 0;
            m_fd[m_id]  = 1'b1;
          end else begin
            m_ptr[m_id] = nxt;
          end
        end
      end
      for (int i = 0; i < N; i++) if (client_restart[i]) m_ptr[i] = 0;
      req_seen = client_req;
    end
  end

  // ---------------------------------------------------------------------------
  // Engine emulation
  // ---------------------------------------------------------------------------
  task automatic burst(input int hold, input bit drop, input bit [N-1:0] rst_mask,
                       output int id, output int addr, output int len, output bit [N-1:0] fd);
    int n;
    n = 0;
    while (!grant_valid && n < 100) begin
      @(posedge clk_in); #1;
      n++;
    end
    if (!grant_valid) begin
      check("grant_timeout", 0, 1);
      id = -1; addr = -1; len = -1; fd = '0;
      return;
    end
    id = grant_id; addr = grant_addr; len = grant_len;
    if (drop) client_req = '0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk_in); #1;
    end
    if (hold > 0) check("valid_held", 32'(grant_valid), 1);
    grant_ready = 1'b1;
    @(posedge clk_in); #1;
    grant_ready    = 1'b0;
    burst_done     = 1'b1;
    client_restart = rst_mask;
    @(posedge clk_in); #1;
    burst_done     = 1'b0;
    client_restart = '0;
    fd = frame_done;
  endtask

  task automatic burst40(output int addr, output int len, output bit fd0);
    int n;
    n = 0;
    while (!valid40 && n < 100) begin
      @(posedge clk_in); #1;
      n++;
    end
    if (!valid40) begin
      check("grant40_timeout", 0, 1);
      addr = -1; len = -1; fd0 = 1'b0;
      return;
    end
    addr = addr40; len = len40;
    ready40 = 1'b1;
    @(posedge clk_in); #1;
    ready40 = 1'b0;
    done40  = 1'b1;
    @(posedge clk_in); #1;
    done40 = 1'b0;
    fd0 = fd40[0];
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int id, addr, len;
  bit [N-1:0] fd;
  bit fd0;
  int ids [7];
  int addrs [7];
  int exp_ids [7];
  int idx3, idx0b;
  int exp40_addr [4];
  int exp40_len [4];
  bit exp40_fd [4];

  initial begin
`ifdef SAME_DIR_PREF_EN
    exp_ids = '{0, 1, 2, 0, 3, 4, 5};
    idx3 = 4; idx0b = 3;
`else
    exp_ids = '{0, 1, 2, 3, 4, 5, 0};
    idx3 = 3; idx0b = 6;
`endif
    exp40_addr = '{0, 16, 32, 0};
    exp40_len  = '{16, 16, 8, 16};
    exp40_fd   = '{1'b0, 1'b0, 1'b1, 1'b0};

    // reset state
    client_req = '1;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_valid", 32'(grant_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_id", 32'(grant_id), 0);
    check("rst_addr", 32'(grant_addr), 0);
    check("rst_len", 32'(grant_len), 0);
    check("rst_wr", 32'(grant_is_write), 0);
    rst_in = 1'b0;

    // no grant before calibration
    for (int k = 0; k < 6; k++) begin
      @(posedge clk_in); #1;
      check("no_grant_before_init", 32'(grant_valid), 0);
    end

    // grant two cycles after init
    init_calib_complete = 1'b1;
    @(posedge clk_in); #1;
    check("init_plus1_valid", 32'(grant_valid), 0);
    @(posedge clk_in); #1;
    check("init_plus2_valid", 32'(grant_valid), 1);
    check("first_id", 32'(grant_id), 0);
    check("first_addr", 32'(grant_addr), 0);
    check("first_len", 32'(grant_len), 16);
    check("first_wr", 32'(grant_is_write), 1);

    // all six requesting
    for (int k = 0; k < 7; k++) begin
      burst(0, 1'b0, '0, id, addr, len, fd);
      ids[k] = id; addrs[k] = addr;
    end
    client_req = '0;
    for (int k = 0; k < 7; k++) check($sformatf("rr_seq_%0d", k), ids[k], exp_ids[k]);
    check("client3_first_addr", addrs[idx3], 49152);
    check("client0_second_addr", addrs[idx0b], 16);

    // client 5 alone for a full frame
    @(posedge clk_in); #1;
    client_restart = 6'b100000;
    @(posedge clk_in); #1;
    client_restart = '0;
    client_req = 6'b100000;
    for (int k = 0; k < 950; k++) begin
      burst(0, 1'b0, '0, id, addr, len, fd);
      if (k == 948) check("c5_no_wrap_949", 32'(fd), 0);
      if (k == 949) check("c5_wrap_950", 32'(fd), 32'(6'b100000));
    end
    burst(0, 1'b0, '0, id, addr, len, fd);
    client_req = '0;
    check("c5_after_wrap_addr", addr, 81920);

    // restart coinciding with burst_done
    client_req = 6'b000100;
    burst(0, 1'b0, '0, id, addr, len, fd);
    check("c2_addr_16", addr, 32768 + 16);
    burst(0, 1'b0, 6'b000100, id, addr, len, fd);
    check("c2_addr_32", addr, 32768 + 32);
    check("c2_restart_no_fd", 32'(fd), 0);
    burst(0, 1'b0, '0, id, addr, len, fd);
    client_req = '0;
    check("c2_addr_after_restart", addr, 32768);

    // request dropped while offered
    client_req = 6'b000010;
    burst(3, 1'b1, '0, id, addr, len, fd);
    check("drop_id", id, 1);
    check("drop_addr", addr, 16400);

    // short final burst, FRAME_WORDS = 40
    req40 = 6'b000001;
    for (int k = 0; k < 4; k++) begin
      burst40(addr, len, fd0);
      if (k == 3) req40 = '0;
      check($sformatf("fw40_addr_%0d", k), addr, exp40_addr[k]);
      check($sformatf("fw40_len_%0d", k), len, exp40_len[k]);
      check($sformatf("fw40_fd_%0d", k), 32'(fd0), 32'(exp40_fd[k]));
    end

    // reset in the middle of a burst
    client_req = 6'b000001;
    begin
      int n;
      n = 0;
      while (!grant_valid && n < 100) begin
        @(posedge clk_in); #1;
        n++;
      end
      check("pre_reset_grant", 32'(grant_valid), 1);
    end
    grant_ready = 1'b1;
    @(posedge clk_in); #1;
    grant_ready = 1'b0;
    check("pre_reset_busy", 32'(busy), 1);
    rst_in = 1'b1;
    #1;
    check("midrst_valid", 32'(grant_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_id", 32'(grant_id), 0);
    check("midrst_addr", 32'(grant_addr), 0);
    check("midrst_len", 32'(grant_len), 0);
    check("midrst_fd", 32'(frame_done), 0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    client_req = '1;
    burst(0, 1'b0, '0, id, addr, len, fd);
    client_req = '0;
    check("post_rst_id", id, 0);
    check("post_rst_addr", addr, 0);
    repeat (4) @(posedge clk_in);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_burst_scheduler.md
Name: dram_burst_scheduler

Overview:
- Round-robin scheduler that shares the single DDR3 MIG UI port between NUM_CLIENTS burst requesters: cam1/cam2/SAD writers and cam1/cam2/HDMI readers.
- Each client owns one frame region in DRAM. The block tracks a per-client word pointer and issues one burst grant at a time (word address, length, direction) to the MIG command engine.
- It sits between the client AXIS FIFOs and the MIG command engine, replacing fixed-order state sequencing with fair, request-driven arbitration.

Parameters:
- NUM_CLIENTS, 6, number of requesters; client index is also its priority slot.
- WR_MASK, 6'b000111, bit i = 1 means client i is a writer, 0 means reader.
- BURST_LEN, 16, maximum 128-bit words per grant.
- FRAME_WORDS, 15200, 128-bit words per frame region.
- REGION_SHIFT, 14, log2 of region size in words; base of client i = i << REGION_SHIFT. Must satisfy 2^REGION_SHIFT >= FRAME_WORDS.
- ADDR_W, 27, width of the word address output.

Ports:
- clk_in  in  1  MIG UI clock.
- rst_in  in  1  asynchronous, active-high reset.
- init_calib_complete  in  1  MIG calibration done; no grant is issued before it is high.
- client_req  in  NUM_CLIENTS  level request; writer has >= BURST_LEN words queued, reader has >= BURST_LEN free FIFO slots.
- client_restart  in  NUM_CLIENTS  one-cycle pulse; client pointer returns to 0 (frame start / tlast).
- grant_valid  out  1  burst grant pending.
- grant_ready  in  1  engine accepts grant.
- grant_id  out  $clog2(NUM_CLIENTS)  granted client.
- grant_is_write  out  1  WR_MASK[grant_id].
- grant_addr  out  ADDR_W  word address = (grant_id << REGION_SHIFT) + ptr[grant_id].
- grant_len  out  $clog2(BURST_LEN)+1  words in burst, 1..BURST_LEN.
- burst_done  in  1  one-cycle pulse from engine when the last word of the accepted burst is issued.
- frame_done  out  NUM_CLIENTS  one-cycle pulse when a client's pointer wraps.
- busy  out  1  high from grant acceptance until burst_done.

Behaviour:
- Reset (async, any state): state = WAIT_INIT. All pointers = 0. rr_last = NUM_CLIENTS-1. grant_valid = 0. grant_id/addr/len = 0. grant_is_write = 0. frame_done = 0. busy = 0.
- States:
  - WAIT_INIT: go to ARB when init_calib_complete = 1.
  - ARB: if any client_req, pick the first requester scanning from rr_last+1 upward with wrap. Register grant_id/addr/len/is_write, set grant_valid = 1, go to OFFER. If no requests, stay in ARB.
  - OFFER: hold all grant outputs stable until grant_ready. On the handshake: grant_valid <= 0, busy <= 1, rr_last <= grant_id, go to BUSY. A grant is never retracted, even if client_req drops.
  - BUSY: on burst_done, go to ARB with busy <= 0. In the same cycle, update ptr[grant_id] += grant_len; if the result is >= FRAME_WORDS, set it to 0 and pulse frame_done[grant_id].
- Latency: a request sampled in ARB at cycle t gives grant_valid at t+1. Minimum turnaround from burst_done to the next grant_valid is 2 cycles.
- grant_len = min(BURST_LEN, FRAME_WORDS - ptr). The final burst of a frame may be short (15200 % 16 = 0, so full by default).
- client_restart[i] clears ptr[i] next cycle. If it coincides with burst_done for client i, restart wins: ptr = 0, no frame_done. If it arrives while client i is in OFFER or BUSY, the outstanding grant is unchanged and the pointer clear applies.
- Pointers are FRAME_WORDS-bounded unsigned values of width $clog2(FRAME_WORDS+1); the address add is zero-extended to ADDR_W.
- burst_done outside BUSY is ignored. grant_ready outside OFFER is ignored.
- init_calib_complete dropping after init does not change state.

Optional Feature:
- SAME_DIR_PREF_EN.
- Defined: in ARB, requesters whose direction matches the previous grant are preferred, still in round-robin order among themselves, for at most 4 consecutive same-direction grants. A 3-bit same_dir_cnt counts them and resets on a direction change. This cuts read/write bus turnarounds.
- Undefined: pure round-robin, same_dir_cnt is absent.

Decomposition:
- Package dram_sched_pkg: state enum (WAIT_INIT, ARB, OFFER, BUSY), region base helper constant REGION_SHIFT default, MAX_SAME_DIR = 4.
- Sub-module rr_arbiter (NUM_CLIENTS, combinational priority rotate from rr_last, with an optional mask input used by SAME_DIR_PREF_EN).

Test Plan:
- Hold init_calib_complete = 0 with all client_req high -> grant_valid stays 0. Raise init -> grant_valid 2 cycles later with grant_id = 0, grant_addr = 0, grant_len = 16, grant_is_write = 1.
- All six requests held, engine acks each burst immediately -> grant_id sequence 0,1,2,3,4,5,0. Client 3's first addr = 3<<14 = 49152. Client 0's second grant addr = 16.
- Only client 5 requesting, 950 bursts -> frame_done[5] pulses on the 950th burst_done, and the next grant_addr = 5<<14 = 81920.
- FRAME_WORDS = 40 -> client 0 grants have len 16, 16, 8 at addr 0, 16, 32, then wrap to 0.
- client_restart[2] pulsed in the same cycle as burst_done for client 2 (ptr 32) -> ptr[2] = 0 and no frame_done. client_req[1] dropped while in OFFER -> grant stays valid and unchanged.
- Assert rst_in mid-BUSY -> all outputs 0 immediately, pointers 0, and the next grant after init is client 0 at addr 0. With SAME_DIR_PREF_EN and all requests held -> grant_id 0,1,2,0,3,4,5,3.
